// File: rtl/score_pkg.sv
// score_pkg: page geometry, slot record and buffer FSM states shared by the note buffer and the renderer
package score_pkg;
   localparam int NUM_SCORES      = 4;
   localparam int SLOTS_PER_SCORE = 16;
   localparam int NOTE_W          = 8;
   localparam int DUR_W           = 4;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [DUR_W-1:0]  duration;
   } slot_t;

   typedef enum logic {IDLE, CLEAR} nb_state_t;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-flop rising-edge detector for level strobes
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);
   logic d_q;

   // remember last cycle's level
   always_ff @(posedge clk or negedge reset)
      if (!reset) d_q <= 1'b0;
      else        d_q <= d;

   assign rise = d & ~d_q;
endmodule

// File: rtl/note_buffer.sv
// note_buffer: captures note events into a 4x16 slot page with a registered read port and a timed page-clear sweep
module note_buffer #(
   parameter int NUM_SCORES      = score_pkg::NUM_SCORES,
   parameter int SLOTS_PER_SCORE = score_pkg::SLOTS_PER_SCORE,
   parameter int NOTE_W          = score_pkg::NOTE_W,
   parameter int DUR_W           = score_pkg::DUR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NOTE_W-1:0] note,
   input  logic [DUR_W-1:0]  duration,
   input  logic              note_dec,
   input  logic              clear,
   input  logic [1:0]        rd_score,
   input  logic [3:0]        rd_slot,
   output logic              rd_valid,
   output logic [NOTE_W-1:0] rd_note,
   output logic [DUR_W-1:0]  rd_duration,
   output logic [1:0]        wr_score,
   output logic [3:0]        wr_slot,
   output logic              busy,
   output logic [7:0]        dropped
);
   import score_pkg::*;

   localparam int DEPTH = NUM_SCORES * SLOTS_PER_SCORE;
   localparam int AW    = $clog2(DEPTH);

   nb_state_t       state, state_nxt;
   logic [AW-1:0]   cur, cur_nxt, sweep, wr_addr, rd_addr;
   logic [DEPTH-1:0] valid;
   slot_t           mem [DEPTH];
   slot_t           pend, wr_data;
   logic            pend_vld, pend_set, pend_clr, wr_en, drop, rise, legal;

   rise_detect u_rise (
      .clk   (clk),
      .reset (reset),
      .d     (note_dec),
      .rise  (rise)
   );

   assign legal    = rise & (duration != '0);
   assign rd_addr  = {rd_score, rd_slot};
   assign wr_score = cur[AW-1:AW-2];
   assign wr_slot  = cur[AW-3:0];
   assign busy     = (state == CLEAR);

   // next state, write request and cursor movement
   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      wr_en     = 1'b0;
      wr_addr   = cur;
      wr_data   = slot_t'({note, duration});
      pend_set  = 1'b0;
      pend_clr  = 1'b0;
      drop      = 1'b0;
      if (state == IDLE) begin
         if (clear) begin
            state_nxt = CLEAR;
            cur_nxt   = '0;
            pend_set  = legal;
         end else if (legal) begin
            wr_en     = 1'b1;
            cur_nxt   = cur + 1'b1;
            state_nxt = (cur == AW'(DEPTH - 1)) ? CLEAR : IDLE;
         end
      end else begin
         drop = legal;
         if (&sweep) begin
            state_nxt = IDLE;
            wr_en     = pend_vld;
            wr_addr   = '0;
            wr_data   = pend;
            cur_nxt   = pend_vld ? AW'(1) : '0;
            pend_clr  = pend_vld;
         end
      end
   end

   // FSM, cursor, sweep, valid bits, pending note and drop counter
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= IDLE;
         cur      <= '0;
         sweep    <= '0;
         valid    <= '0;
         pend_vld <= 1'b0;
         pend     <= '0;
         dropped  <= '0;
      end else begin
         state <= state_nxt;
         cur   <= cur_nxt;
         sweep <= (state == CLEAR) ? sweep + 1'b1 : '0;
         if (state == CLEAR) valid[sweep] <= 1'b0;
         if (wr_en) valid[wr_addr] <= 1'b1;
         if (pend_set) begin
            pend_vld <= 1'b1;
            pend     <= wr_data;
         end else if (pend_clr) pend_vld <= 1'b0;
         if (drop && dropped != '1) dropped <= dropped + 1'b1;
      end

   // note storage carries no reset; validity lives in the valid vector
   always_ff @(posedge clk)
      if (wr_en) mem[wr_addr] <= wr_data;

   // registered read port, independent of FSM state
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rd_valid    <= 1'b0;
         rd_note     <= '0;
         rd_duration <= '0;
      end else begin
         rd_valid    <= valid[rd_addr];
         rd_note     <= mem[rd_addr].note;
         rd_duration <= mem[rd_addr].duration;
      end
endmodule

// File: tb/tb_note_buffer.sv
// tb_note_buffer: directed self-checking bench for note_buffer
module tb_note_buffer;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] note = '0;
   logic [3:0] duration = '0;
   logic       note_dec = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] rd_score = '0;
   logic [3:0] rd_slot = '0;
   logic       rd_valid, busy;
   logic [7:0] rd_note, dropped;
   logic [3:0] rd_duration, wr_slot;
   logic [1:0] wr_score;
   int         n_pass = 0;
   int         n_total = 0;

   note_buffer dut (
      .clk         (clk),
      .reset       (reset),
      .note        (note),
      .duration    (duration),
      .note_dec    (note_dec),
      .clear       (clear),
      .rd_score    (rd_score),
      .rd_slot     (rd_slot),
      .rd_valid    (rd_valid),
      .rd_note     (rd_note),
      .rd_duration (rd_duration),
      .wr_score    (wr_score),
      .wr_slot     (wr_slot),
      .busy        (busy),
      .dropped     (dropped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      note_dec = 1'b0;
      clear = 1'b0;
      repeat (3) tick;
      reset = 1'b1;
      tick;
   endtask

   task automatic event_in(input logic [7:0] n, input logic [3:0] d);
      note = n;
      duration = d;
      note_dec = 1'b1;
      tick;
      note_dec = 1'b0;
      tick;
   endtask

   task automatic rd(input logic [1:0] s, input logic [3:0] sl);
      rd_score = s;
      rd_slot = sl;
      tick;
   endtask

   task automatic chk_cursor(input string tag, input logic [1:0] s, input logic [3:0] sl);
      chk({tag, "_score"}, wr_score, s);
      chk({tag, "_slot"}, wr_slot, sl);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 200) begin
         tick;
         n++;
      end
      chk(tag, busy, 0);
   endtask

   initial begin
      do_reset;
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_note", rd_note, 0);
      chk("rst_rd_dur", rd_duration, 0);
      chk_cursor("rst_cur", 0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dropped", dropped, 0);

      event_in(8'h3C, 4'd4);
      rd(0, 0);
      chk("basic_valid", rd_valid, 1);
      chk("basic_note", rd_note, 8'h3C);
      chk("basic_dur", rd_duration, 4);
      chk_cursor("basic_cur", 0, 1);

      note = 8'h11;
      duration = 4'd1;
      note_dec = 1'b1;
      repeat (10) tick;
      note_dec = 1'b0;
      tick;
      chk_cursor("held_cur", 0, 2);
      rd(0, 1);
      chk("held_valid", rd_valid, 1);
      chk("held_note", rd_note, 8'h11);
      rd(0, 2);
      chk("held_next_empty", rd_valid, 0);
      event_in(8'h22, 4'd0);
      chk_cursor("zdur_cur", 0, 2);
      rd(0, 2);
      chk("zdur_empty", rd_valid, 0);

      do_reset;
      for (int i = 0; i < 16; i++) event_in(8'h50 + 8'(i), 4'd1);
      chk_cursor("wrap_cur", 1, 0);
      rd(0, 15);
      chk("wrap_valid", rd_valid, 1);
      chk("wrap_note", rd_note, 8'h5F);
      rd(1, 0);
      chk("wrap_next_empty", rd_valid, 0);

      for (int i = 16; i < 63; i++) event_in(8'h50 + 8'(i), 4'd1);
      chk_cursor("p63_cur", 3, 15);
      chk("p63_busy", busy, 0);
      note = 8'hEE;
      duration = 4'd2;
      note_dec = 1'b1;
      tick;
      chk("full_busy_rise", busy, 1);
      chk_cursor("full_cur", 0, 0);
      begin
         int cnt = 1;
         for (int k = 0; k < 200; k++) begin
            note_dec = (k == 4 || k == 10 || k == 20);
            duration = 4'd1;
            tick;
            if (!busy) break;
            cnt++;
         end
         chk("full_busy_len", cnt, 64);
      end
      note_dec = 1'b0;
      chk("full_dropped", dropped, 3);
      chk_cursor("full_after_cur", 0, 0);
      rd(0, 0);
      chk("full_swept_00", rd_valid, 0);
      rd(2, 7);
      chk("full_swept_27", rd_valid, 0);
      rd(3, 15);
      chk("full_swept_315", rd_valid, 0);

      note = 8'h40;
      duration = 4'd2;
      note_dec = 1'b1;
      clear = 1'b1;
      tick;
      clear = 1'b0;
      note_dec = 1'b0;
      chk("clr_busy", busy, 1);
      wait_idle("clr_done");
      chk_cursor("clr_cur", 0, 1);
      chk("clr_dropped", dropped, 3);
      rd(0, 0);
      chk("clr_pend_valid", rd_valid, 1);
      chk("clr_pend_note", rd_note, 8'h40);
      chk("clr_pend_dur", rd_duration, 2);

      rd_score = 0;
      rd_slot = 1;
      note = 8'h77;
      duration = 4'd3;
      note_dec = 1'b1;
      tick;
      chk("wtr_old", rd_valid, 0);
      note_dec = 1'b0;
      tick;
      chk("wtr_new_valid", rd_valid, 1);
      chk("wtr_new_note", rd_note, 8'h77);
      chk("wtr_new_dur", rd_duration, 3);

      clear = 1'b1;
      tick;
      clear = 1'b0;
      repeat (20) tick;
      chk("mid_busy", busy, 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", rd_valid, 0);
      chk("mid_rst_note", rd_note, 0);
      chk("mid_rst_dur", rd_duration, 0);
      chk("mid_rst_dropped", dropped, 0);
      chk_cursor("mid_rst_cur", 0, 0);
      reset = 1'b1;
      tick;
      tick;
      chk("mid_stay_idle", busy, 0);
      event_in(8'h99, 4'd5);
      rd(0, 0);
      chk("mid_next_valid", rd_valid, 1);
      chk("mid_next_note", rd_note, 8'h99);
      chk_cursor("mid_next_cur", 0, 1);
      rd(0, 1);
      chk("mid_next_empty", rd_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/note_buffer.md
# note_buffer

Upstream companion of the score renderer. Captures each decoded note event (`note`, `duration`, `note_dec`) into a fixed grid of 4 staves × 16 slots. A read port lets the renderer fetch slot contents by (score, slot) with one-cycle latency. When the page fills, or `clear` is pulsed, all slots are wiped in a timed sweep, and any note that triggered the wrap is written to slot 0 of the fresh page.

## Interface

Parameters:
- `NUM_SCORES`, 4, staves per page
- `SLOTS_PER_SCORE`, 16, note positions per staff
- `NOTE_W`, 8, note code width
- `DUR_W`, 4, duration code width

Ports:
- `clk`  in  1  system clock (VGA pixel clock domain)
- `reset`  in  1  asynchronous, active-low reset
- `note`  in  NOTE_W  decoded note code, sampled on `note_dec` rising edge
- `duration`  in  DUR_W  duration code, sampled with `note`
- `note_dec`  in  1  note-valid level; one event per rising edge
- `clear`  in  1  single-cycle page-clear request
- `rd_score`  in  2  read staff index
- `rd_slot`  in  4  read slot index
- `rd_valid`  out  1  slot holds a note (registered)
- `rd_note`  out  NOTE_W  stored note (registered)
- `rd_duration`  out  DUR_W  stored duration (registered)
- `wr_score`  out  2  staff of next write cursor
- `wr_slot`  out  4  slot of next write cursor
- `busy`  out  1  high while in CLEAR
- `dropped`  out  8  saturating count of events lost during CLEAR

## Operation

- Edge detect:
  - `note_dec_d` registers `note_dec`.
  - `rise = note_dec & ~note_dec_d`.
  - Holding `note_dec` high yields exactly one event.
- Event with `duration == 0`:
  - Discarded; the cursor does not move.
  - This is not counted in `dropped`.
- FSM states: IDLE, CLEAR.
- IDLE, legal `rise`:
  - Write {`note`, `duration`} to the cursor slot and set its valid bit.
  - Advance the cursor: `wr_slot` +1; on slot 15 → `wr_slot` 0 and `wr_score` +1.
- IDLE, `rise` while cursor is (3,15):
  - Write that slot, then enter CLEAR with `pend_full` = 1 and the cursor reset to (0,0).
  - No pending note is held in this case.
- IDLE, `clear` = 1: enter CLEAR with `pend_full` = 0.
- IDLE, `clear` and a legal `rise` in the same cycle:
  - Clear wins.
  - The note is latched into the pending register (`pend_vld` = 1).
- CLEAR:
  - A 6-bit sweep counter zeroes one valid bit per cycle, covering 64 cycles (index 0..63).
  - Note/duration storage is not cleared.
  - After index 63:
    - If `pend_vld`, write the pending note to (0,0), set the cursor to (0,1), and clear `pend_vld`.
    - Otherwise the cursor is (0,0).
    - Return to IDLE.
- Legal `rise` during CLEAR: not stored; `dropped` +1, saturating at 255.
- `clear` during CLEAR: ignored; the sweep does not restart.
- Read port: `rd_*` registers the slot at `rd_score`·16+`rd_slot` every cycle, independent of FSM state.

## Timing

- Reset values:
  - `rd_valid`, `rd_note`, `rd_duration`, `wr_score`, `wr_slot`, `busy`, `dropped`: all 0.
  - All valid bits 0; state IDLE; `pend_vld` 0; `note_dec_d` 0.
- Write latency: `note_dec` rises at edge N; the slot is valid after edge N+1.
- Read latency: address at edge N; data at `rd_*` after edge N+1.
  - The renderer applies the address two cycles ahead, matching its pipeline.
- Write-then-read to the same slot: a read sampled at the write edge returns the old contents; the next cycle returns the new contents.
- `busy`:
  - Rises on the edge entering CLEAR.
  - Falls on the edge that returns to IDLE.
  - Stays high for exactly 64 cycles.
- Reset asserted mid-CLEAR: everything returns to reset values immediately (asynchronous). The sweep does not resume.

## Structure

- Package `score_pkg`:
  - Constants: `NUM_SCORES`, `SLOTS_PER_SCORE`, `NOTE_W`, `DUR_W`.
  - `slot_t` struct {note, duration}.
  - `nb_state_t` enum {IDLE, CLEAR}.
  - The renderer imports the same constants.
- Sub-module `rise_detect`: one-flop edge detector with asynchronous active-low reset, reusable for other strobes.
- Storage:
  - `slot_t` array of 64 entries, no reset.
  - Separate 64-bit valid register with reset.

## Test plan

- **Basic capture.** Reset; pulse `note_dec` with note 0x3C, dur 4.
  - Read (0,0) → `rd_valid` 1, 0x3C, 4.
  - Cursor at (0,1).
- **Held level and zero duration.**
  - Hold `note_dec` high 10 cycles → one slot written.
  - Event with dur 0 → no write, cursor unchanged.
- **Staff wrap.** Issue 16 events.
  - Cursor at (1,0).
  - (0,15) holds the 16th note.
- **Page full.** Issue 64 events.
  - `busy` high 64 cycles; all valid bits 0 afterwards; cursor (0,0).
  - Three events during CLEAR → `dropped` = 3.
- **Clear with simultaneous note.** Assert `clear` and a `rise` (0x40, dur 2) in the same cycle.
  - After CLEAR, (0,0) holds 0x40/2; cursor (0,1).
- **Reset mid-CLEAR.** Assert `reset` low at sweep index 20.
  - All outputs 0, state IDLE.
  - Next event writes (0,0).
